// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter that sequences one access at a time onto a
// single-port memory valid/ready interface, with an optional stall timeout.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_wr_rd,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*WIDTH-1:0]      req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              req_err,
    output logic [WIDTH-1:0]        req_rdata,
    output logic                    mem_valid,
    output logic                    mem_wr_rd,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]        mem_wdata,
    input  logic [WIDTH-1:0]        mem_rdata,
    input  logic                    mem_ready,
    output logic                    grant,
    output logic                    busy
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    grant_q;
    logic                    last_q;
    logic [CW-1:0]           cnt_q;
    logic                    busy_q;
    logic                    mem_valid_q;
    logic                    mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [WIDTH-1:0]        mem_wdata_q;
    logic [1:0]              req_ready_q;
    logic [1:0]              req_err_q;
    logic [WIDTH-1:0]        req_rdata_q;

    logic                    win_d;
    logic                    win_wr_rd_d;
    logic [ADDR_WIDTH-1:0]   win_addr_d;
    logic [WIDTH-1:0]        win_wdata_d;

    // A tie goes to the requester that did not win last time.
    always_comb begin
        win_d = 1'b0;
        if (req_valid == 2'b11) begin
            win_d = ~last_q;
        end else if (req_valid[1]) begin
            win_d = 1'b1;
        end
        win_wr_rd_d = win_d ? req_wr_rd[1] : req_wr_rd[0];
        win_addr_d  = win_d ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
        win_wdata_d = win_d ? req_wdata[WIDTH +: WIDTH] : req_wdata[0 +: WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            req_ready_q <= 2'b00;
            req_err_q   <= 2'b00;
            req_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant_q     <= win_d;
                        last_q      <= win_d;
                        mem_valid_q <= 1'b1;
                        mem_wr_rd_q <= win_wr_rd_d;
                        mem_addr_q  <= win_addr_d;
                        mem_wdata_q <= win_wdata_d;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (mem_ready) begin
                        req_rdata_q          <= mem_wr_rd_q ? '0 : mem_rdata;
                        mem_valid_q          <= 1'b0;
                        req_ready_q[grant_q] <= 1'b1;
                        req_err_q            <= 2'b00;
                        state_q              <= S_RESP;
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        req_rdata_q          <= '0;
                        mem_valid_q          <= 1'b0;
                        req_ready_q[grant_q] <= 1'b1;
                        req_err_q[grant_q]   <= 1'b1;
                        state_q              <= S_RESP;
                    end
                end
                S_RESP: begin
                    req_ready_q <= 2'b00;
                    req_err_q   <= 2'b00;
                    req_rdata_q <= '0;
                    cnt_q       <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign req_err   = req_err_q;
    assign req_rdata = req_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_wr_rd = mem_wr_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single accesses, fairness,
// timeout and mid-access reset, each checked against hand-computed values.
module tb_mem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 16;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            res;
    logic [1:0]      req_valid;
    logic [1:0]      req_wr_rd;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      req_err;
    logic [DW-1:0]   req_rdata;
    logic            mem_valid;
    logic            mem_wr_rd;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ready;
    logic            grant;
    logic            busy;

    int n_asserts = 0;
    int n_fail    = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .res       (res),
        .req_valid (req_valid),
        .req_wr_rd (req_wr_rd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_wr_rd (mem_wr_rd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        res       = 1'b1;
        req_valid = 2'b00;
        req_wr_rd = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        // 1. reset and idle
        tick();
        tick();
        check("rst_mem_valid", 32'(mem_valid), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_req_err",   32'(req_err),   32'h0);
        check("rst_req_rdata", 32'(req_rdata), 32'h0);
        check("rst_grant",     32'(grant),     32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        res = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_mem_valid", 32'(mem_valid), 32'h0);
            check("idle_busy",      32'(busy),      32'h0);
        end

        // 2. requester 0 write, ready on 2nd ISSUE edge
        req_valid = 2'b01;
        req_wr_rd = 2'b01;
        req_addr[0 +: AW]  = 6'h05;
        req_wdata[0 +: DW] = 16'hBEEF;
        mem_rdata = 16'h1234;
        tick();
        check("wr_mem_valid", 32'(mem_valid), 32'h1);
        check("wr_mem_addr",  32'(mem_addr),  32'h05);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_mem_wr_rd", 32'(mem_wr_rd), 32'h1);
        check("wr_grant",     32'(grant),     32'h0);
        check("wr_busy",      32'(busy),      32'h1);
        tick();
        check("wr_issue2_valid", 32'(mem_valid), 32'h1);
        check("wr_issue2_ready", 32'(req_ready), 32'h0);
        mem_ready = 1'b1;
        tick();
        check("wr_done_valid", 32'(mem_valid), 32'h0);
        check("wr_done_ready", 32'(req_ready), 32'h1);
        check("wr_done_err",   32'(req_err),   32'h0);
        check("wr_done_rdata", 32'(req_rdata), 32'h0);
        check("wr_done_busy",  32'(busy),      32'h1);
        req_valid = 2'b00;
        mem_ready = 1'b0;
        tick();
        check("wr_resp_ready", 32'(req_ready), 32'h0);
        check("wr_resp_busy",  32'(busy),      32'h0);

        // 3. requester 1 read, ready on 1st ISSUE edge
        req_valid = 2'b10;
        req_wr_rd = 2'b00;
        req_addr[AW +: AW] = 6'h05;
        tick();
        check("rd_mem_valid", 32'(mem_valid), 32'h1);
        check("rd_mem_wr_rd", 32'(mem_wr_rd), 32'h0);
        check("rd_mem_addr",  32'(mem_addr),  32'h05);
        check("rd_grant",     32'(grant),     32'h1);
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        check("rd_done_ready", 32'(req_ready), 32'h2);
        check("rd_done_rdata", 32'(req_rdata), 32'hBEEF);
        check("rd_done_err",   32'(req_err),   32'h0);
        req_valid = 2'b00;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        tick();
        check("rd_resp_ready", 32'(req_ready), 32'h0);
        check("rd_resp_rdata", 32'(req_rdata), 32'h0);
        check("rd_resp_grant", 32'(grant),     32'h1);

        // 4. both requesters continuously active, immediate ready
        req_wr_rd = 2'b11;
        req_addr[0 +: AW]  = 6'h0A;
        req_addr[AW +: AW] = 6'h15;
        req_valid = 2'b11;
        mem_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            automatic logic g = t[0];
            tick();
            check("rr_grant",     32'(grant),     32'(g));
            check("rr_mem_valid", 32'(mem_valid), 32'h1);
            check("rr_mem_addr",  32'(mem_addr),  g ? 32'h15 : 32'h0A);
            tick();
            check("rr_ready", 32'(req_ready), g ? 32'h2 : 32'h1);
            req_valid[g] = 1'b0;
            tick();
            check("rr_resp_ready", 32'(req_ready), 32'h0);
            req_valid[g] = 1'b1;
        end
        req_valid = 2'b00;
        mem_ready = 1'b0;
        tick();
        check("rr_end_busy", 32'(busy), 32'h0);

        // 5a. timeout: mem_ready tied low
        req_valid = 2'b01;
        req_wr_rd = 2'b00;
        req_addr[0 +: AW] = 6'h3F;
        mem_rdata = 16'hAAAA;
        tick();
        check("to_mem_valid", 32'(mem_valid), 32'h1);
        for (int i = 1; i < TO; i++) begin
            tick();
            check("to_wait_valid", 32'(mem_valid), 32'h1);
            check("to_wait_ready", 32'(req_ready), 32'h0);
        end
        tick();
        check("to_done_valid", 32'(mem_valid), 32'h0);
        check("to_done_ready", 32'(req_ready), 32'h1);
        check("to_done_err",   32'(req_err),   32'h1);
        check("to_done_rdata", 32'(req_rdata), 32'h0);
        req_valid = 2'b00;
        tick();
        check("to_resp_err",   32'(req_err),   32'h0);
        check("to_resp_ready", 32'(req_ready), 32'h0);

        // 5b. ready arrives on the 16th ISSUE edge: completes without error
        req_valid = 2'b10;
        req_wr_rd = 2'b00;
        req_addr[AW +: AW] = 6'h01;
        tick();
        check("late_grant", 32'(grant), 32'h1);
        for (int i = 1; i < TO; i++) begin
            tick();
        end
        check("late_pre_valid", 32'(mem_valid), 32'h1);
        mem_ready = 1'b1;
        mem_rdata = 16'h5A5A;
        tick();
        check("late_ready", 32'(req_ready), 32'h2);
        check("late_err",   32'(req_err),   32'h0);
        check("late_rdata", 32'(req_rdata), 32'h5A5A);
        req_valid = 2'b00;
        mem_ready = 1'b0;
        tick();

        // 6. reset during ISSUE aborts; held request is granted again
        req_valid = 2'b01;
        req_wr_rd = 2'b01;
        req_addr[0 +: AW]  = 6'h22;
        req_wdata[0 +: DW] = 16'h1357;
        tick();
        check("ab_mem_valid", 32'(mem_valid), 32'h1);
        tick();
        check("ab_issue_valid", 32'(mem_valid), 32'h1);
        res = 1'b1;
        tick();
        check("ab_rst_valid", 32'(mem_valid), 32'h0);
        check("ab_rst_ready", 32'(req_ready), 32'h0);
        check("ab_rst_busy",  32'(busy),      32'h0);
        res = 1'b0;
        tick();
        check("ab_regrant_valid", 32'(mem_valid), 32'h1);
        check("ab_regrant_grant", 32'(grant),     32'h0);
        check("ab_regrant_addr",  32'(mem_addr),  32'h22);
        check("ab_regrant_wdata", 32'(mem_wdata), 32'h1357);
        mem_ready = 1'b1;
        tick();
        check("ab_done_ready", 32'(req_ready), 32'h1);
        check("ab_done_err",   32'(req_err),   32'h0);
        req_valid = 2'b00;
        mem_ready = 1'b0;
        tick();
        check("ab_resp_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port memory valid/ready interface (wr_rd, addr, wdata, rdata, ready, valid).
- Registers the winning request, drives the memory handshake, and returns rdata/completion to the owner.
- Aborts a stalled access with an error after a programmable timeout.
- Sits between the testbench/agent-side masters and the memory DUT port.

Parameters:
- ADDR_WIDTH, 6, memory address width.
- WIDTH, 16, data width.
- TIMEOUT, 16, max ISSUE cycles waiting for mem_ready; 0 disables the timeout.

Ports:
- clk  input  1  clock, all logic on posedge.
- res  input  1  synchronous active-high reset.
- req_valid  input  2  per-requester request; held high until its req_ready.
- req_wr_rd  input  2  per-requester 1=write, 0=read.
- req_addr  input  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  2*WIDTH  requester i at [i*WIDTH +: WIDTH].
- req_ready  output  2  one-cycle completion pulse to the owner.
- req_err  output  2  qualifies req_ready: 1 = timed out.
- req_rdata  output  WIDTH  read data, valid only while req_ready is high.
- mem_valid  output  1  memory request.
- mem_wr_rd  output  1  memory direction.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  WIDTH  memory write data.
- mem_rdata  input  WIDTH  memory read data.
- mem_ready  input  1  memory completion.
- grant  output  1  current or last owner index.
- busy  output  1  high in ISSUE or RESP.

Behaviour:
- Clock and reset: one clock clk; reset res is synchronous and active-high.
- Reset: every output is 0, state=IDLE, timeout counter=0, last-grant pointer=1 so requester 0 wins the first tie. Asserting res in any state aborts the in-flight access. At that edge mem_valid drops, no req_ready is issued, and nothing is reported to the requester.
- FSM states are IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - No req_valid: stay in IDLE.
  - One req_valid: grant that requester.
  - Both req_valid: grant the requester that is not the last-grant pointer.
  - On grant: latch its wr_rd/addr/wdata into the mem_* registers, set grant, update the pointer, set mem_valid=1, go to ISSUE. mem_valid rises at the edge after req_valid is first sampled.
- ISSUE:
  - mem_valid stays 1 and mem_* stay stable. The counter increments each edge.
  - mem_ready sampled high: capture mem_rdata (read) or 0 (write) into req_rdata, clear mem_valid, set req_ready[grant]=1 with req_err=0, go to RESP.
  - Otherwise, if TIMEOUT!=0 and this is the TIMEOUT-th ISSUE edge: clear mem_valid, set req_ready[grant]=1, req_err[grant]=1, req_rdata=0, go to RESP.
  - mem_ready and timeout on the same edge: mem_ready wins and the access completes normally.
- RESP (one cycle): clear req_ready/req_err/req_rdata and the counter, go to IDLE. The requester must drop req_valid on the edge it samples req_ready. A re-asserted req_valid is treated as a new request.
- No request is accepted while busy. Incoming req_valid simply waits; there is no queueing beyond the held request.
- Latency with mem_ready returned on the first ISSUE edge: req_valid sampled at edge N → mem_valid high after N → req_ready high after edge N+1 → IDLE after N+2. Peak throughput is one access per 3 cycles.
- Fairness: with both requesters continuously active, grants alternate strictly 0,1,0,1. No starvation.
- mem_rdata is sampled only on the completing edge. req_rdata for a write is 0.

Test Plan:
1. res=1 for 2 cycles, then release with no requests → all outputs 0, busy=0, mem_valid never rises.
2. Requester 0 writes addr=0x05, wdata=0xBEEF; memory asserts ready on the 2nd ISSUE edge → mem_valid high for 2 cycles with addr=0x05/wdata=0xBEEF/wr_rd=1; one req_ready[0] pulse, req_err=0, req_rdata=0.
3. Requester 1 reads addr=0x05; memory returns rdata=0xBEEF with ready on the 1st edge → req_ready[1] pulse with req_rdata=0xBEEF; grant=1.
4. Both requesters hold req_valid for 4 transactions each → grant order 0,1,0,1,...; each completion 3 cycles apart with immediate ready.
5. TIMEOUT=16, mem_ready tied 0 → mem_valid high exactly 16 cycles, then req_ready=1 with req_err=1 and req_rdata=0. In a separate run, ready arrives on the 16th edge → req_err=0.
6. res asserted mid-ISSUE with mem_valid=1 → next edge mem_valid=0, no req_ready pulse; after release, the requester still holding req_valid is granted again.
